// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the two-requester block RAM arbiter.
// State codes are plain localparams so older tools can consume the package unchanged.
package pw_mem_arb_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 8192;
    localparam int unsigned MEM_ADR_W_DEFAULT = 13;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t StIdle   = 2'd0;
    localparam arb_state_t StAccess = 2'd1;
    localparam arb_state_t StResp   = 2'd2;

    typedef enum logic {
        ReqIdA = 1'b0,
        ReqIdB = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes plus block RAM port of the arbiter.
// slave = arbiter side, master = requesters and RAM side.
interface mem_bus_arbiter_if #(
    parameter int unsigned MEM_ADR_W = 13
);

    logic                 ReqA;
    logic                 WrtA;
    logic [15:0]          AdrA;
    logic [7:0]           DataInA;
    logic [7:0]           DataOutA;
    logic                 AckA;

    logic                 ReqB;
    logic                 WrtB;
    logic [15:0]          AdrB;
    logic [7:0]           DataInB;
    logic [7:0]           DataOutB;
    logic                 AckB;

    logic                 MemEn;
    logic                 MemWe;
    logic [MEM_ADR_W-1:0] MemAdr;
    logic [7:0]           MemDin;
    logic [7:0]           MemDout;

    modport slave (
        input  ReqA, WrtA, AdrA, DataInA,
        input  ReqB, WrtB, AdrB, DataInB,
        input  MemDout,
        output DataOutA, AckA, DataOutB, AckB,
        output MemEn, MemWe, MemAdr, MemDin
    );

    modport master (
        output ReqA, WrtA, AdrA, DataInA,
        output ReqB, WrtB, AdrB, DataInB,
        output MemDout,
        input  DataOutA, AckA, DataOutB, AckB,
        input  MemEn, MemWe, MemAdr, MemDin
    );

endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin tie-break: a sole requester wins, on a tie the side not
// granted last wins. The last-grant flop only moves when the grant is taken.
module rr_arbiter2
    import pw_mem_arb_pkg::*;
(
    input  logic    Clk,
    input  logic    Reset,
    input  logic    ReqA,
    input  logic    ReqB,
    input  logic    Take,
    output req_id_t Grant
);

    req_id_t last_q, last_d;

    always_comb begin
        if (ReqA && !ReqB) begin
            Grant = ReqIdA;
        end else if (ReqB && !ReqA) begin
            Grant = ReqIdB;
        end else begin
            Grant = (last_q == ReqIdB) ? ReqIdA : ReqIdB;
        end
    end

    always_comb begin
        last_d = last_q;
        if (Take) begin
            last_d = Grant;
        end
    end

    // Pointing at B after reset lets A win the first tie.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_q <= ReqIdB;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port block RAM between requesters A and B.
// Each transaction runs IDLE -> ACCESS -> RESP, acking two cycles after the grant.
module mem_bus_arbiter
    import pw_mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned MEM_ADR_W = MEM_ADR_W_DEFAULT
) (
    input logic              Clk,
    input logic              Reset,
    mem_bus_arbiter_if.slave bus_io
);

    arb_state_t  state_q, state_d;
    req_id_t     grant_q, grant_d;
    req_id_t     arb_grant;
    logic        take;
    logic        wrt_q, wrt_d;
    logic [15:0] adr_q, adr_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  dout_a_q, dout_a_d;
    logic [7:0]  dout_b_q, dout_b_d;
    logic        in_range;
    logic        in_resp;
    logic        rd_resp_a;
    logic        rd_resp_b;
    logic [7:0]  rd_data;

    rr_arbiter2 u_rr_arbiter2 (
        .Clk   (Clk),
        .Reset (Reset),
        .ReqA  (bus_io.ReqA),
        .ReqB  (bus_io.ReqB),
        .Take  (take),
        .Grant (arb_grant)
    );

    // Out-of-range accesses never touch the RAM and read back as zero.
    assign in_range = ({16'd0, adr_q} < MEM_WORDS);
    assign rd_data  = in_range ? bus_io.MemDout : 8'h00;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        wrt_d    = wrt_q;
        adr_d    = adr_q;
        din_d    = din_q;
        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;
        take     = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_io.ReqA || bus_io.ReqB) begin
                    take    = 1'b1;
                    state_d = StAccess;
                    grant_d = arb_grant;
                    if (arb_grant == ReqIdA) begin
                        wrt_d = bus_io.WrtA;
                        adr_d = bus_io.AdrA;
                        din_d = bus_io.DataInA;
                    end else begin
                        wrt_d = bus_io.WrtB;
                        adr_d = bus_io.AdrB;
                        din_d = bus_io.DataInB;
                    end
                end
            end
            StAccess: begin
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
                if (rd_resp_a) begin
                    dout_a_d = rd_data;
                end
                if (rd_resp_b) begin
                    dout_b_d = rd_data;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            grant_q  <= ReqIdA;
            wrt_q    <= 1'b0;
            adr_q    <= 16'h0000;
            din_q    <= 8'h00;
            dout_a_q <= 8'h00;
            dout_b_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            wrt_q    <= wrt_d;
            adr_q    <= adr_d;
            din_q    <= din_d;
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
        end
    end

    assign in_resp   = (state_q == StResp);
    assign rd_resp_a = in_resp && !wrt_q && (grant_q == ReqIdA);
    assign rd_resp_b = in_resp && !wrt_q && (grant_q == ReqIdB);

    assign bus_io.AckA = in_resp && (grant_q == ReqIdA);
    assign bus_io.AckB = in_resp && (grant_q == ReqIdB);

    // RAM read data arrives in RESP, so the read Ack cycle bypasses the holding flop.
    assign bus_io.DataOutA = rd_resp_a ? rd_data : dout_a_q;
    assign bus_io.DataOutB = rd_resp_b ? rd_data : dout_b_q;

    assign bus_io.MemEn  = (state_q == StAccess) && in_range;
    assign bus_io.MemWe  = (state_q == StAccess) && in_range && wrt_q;
    assign bus_io.MemAdr = adr_q[MEM_ADR_W-1:0];
    assign bus_io.MemDin = din_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vectors, corner sequences and
// random traffic against a cycle-count / scoreboard reference model.
module tb_mem_bus_arbiter;

    localparam int unsigned MemWords = 8192;
    localparam int unsigned AdrW     = 13;

    logic clk;
    logic rst;
    logic ram_clr;

    mem_bus_arbiter_if #(.MEM_ADR_W(AdrW)) bus ();

    mem_bus_arbiter #(
        .MEM_WORDS (MemWords),
        .MEM_ADR_W (AdrW)
    ) dut (
        .Clk    (clk),
        .Reset  (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM stand-in: read-first, one cycle read latency.
    logic [7:0] ram [MemWords];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < int'(MemWords); i++) ram[i] <= 8'h00;
            bus.MemDout <= 8'h00;
        end else if (bus.MemEn) begin
            if (bus.MemWe) ram[bus.MemAdr] <= bus.MemDin;
            bus.MemDout <= ram[bus.MemAdr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: expected memory contents, one outstanding transaction
    // with its predicted Ack cycle, the earliest cycle a new grant may happen.
    logic [7:0]  ref_mem [MemWords];
    logic        pend;
    int          p_cyc;
    logic        p_who;
    logic        p_wrt;
    logic [15:0] p_adr;
    logic [7:0]  p_din;
    logic        last_who;
    int          next_arb;
    logic [7:0]  exp_da;
    logic [7:0]  exp_db;
    logic        ack_a_seen;
    logic        ack_b_seen;

    typedef struct {
        logic        who;
        logic        wrt;
        logic [15:0] adr;
        logic [7:0]  din;
        logic [7:0]  exp_dout;
        int          exp_en;
    } vec_t;

    vec_t vecs [10];

    function automatic logic in_rng(input logic [15:0] a);
        return 32'(a) < MemWords;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_arb();
        logic w;
        if (rst) begin
            // A write already in its RAM cycle still lands.
            if (pend && cyc == p_cyc - 1 && p_wrt && in_rng(p_adr))
                ref_mem[p_adr[AdrW-1:0]] = p_din;
            pend     = 1'b0;
            last_who = 1'b1;
            next_arb = cyc + 1;
            exp_da   = 8'h00;
            exp_db   = 8'h00;
        end else if (!pend && cyc >= next_arb && (bus.ReqA || bus.ReqB)) begin
            if (bus.ReqA && bus.ReqB) w = ~last_who;
            else                      w = bus.ReqB;
            pend     = 1'b1;
            p_cyc    = cyc + 2;
            p_who    = w;
            p_wrt    = w ? bus.WrtB : bus.WrtA;
            p_adr    = w ? bus.AdrB : bus.AdrA;
            p_din    = w ? bus.DataInB : bus.DataInA;
            last_who = w;
            next_arb = cyc + 3;
        end
    endtask

    task automatic check_cycle();
        logic       ea, eb, een;
        logic [7:0] rd;
        ea  = pend && cyc == p_cyc && !p_who;
        eb  = pend && cyc == p_cyc && p_who;
        een = pend && cyc == p_cyc - 1 && in_rng(p_adr);
        chk("ack_a", 32'(bus.AckA), 32'(ea));
        chk("ack_b", 32'(bus.AckB), 32'(eb));
        chk("mem_en", 32'(bus.MemEn), 32'(een));
        chk("mem_we", 32'(bus.MemWe), 32'(een && p_wrt));
        if (een) chk("mem_adr", 32'(bus.MemAdr), 32'(p_adr[AdrW-1:0]));
        if (een && p_wrt) chk("mem_din", 32'(bus.MemDin), 32'(p_din));
        if (ea || eb) begin
            if (!p_wrt) begin
                rd = in_rng(p_adr) ? ref_mem[p_adr[AdrW-1:0]] : 8'h00;
                if (p_who) exp_db = rd;
                else       exp_da = rd;
            end else if (in_rng(p_adr)) begin
                ref_mem[p_adr[AdrW-1:0]] = p_din;
            end
            pend = 1'b0;
        end
        chk("dout_a", 32'(bus.DataOutA), 32'(exp_da));
        chk("dout_b", 32'(bus.DataOutB), 32'(exp_db));
        ack_a_seen = bus.AckA;
        ack_b_seen = bus.AckB;
    endtask

    task automatic tick();
        model_arb();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    // Single transaction from an idle DUT; returns in the cycle after the Ack.
    task automatic do_txn(input logic who, input logic wrt, input logic [15:0] adr,
                          input logic [7:0] din, output logic [7:0] dout,
                          output int lat, output int en_cnt, output int we_cnt);
        logic got;
        if (who) begin
            bus.WrtB = wrt; bus.AdrB = adr; bus.DataInB = din; bus.ReqB = 1'b1;
        end else begin
            bus.WrtA = wrt; bus.AdrA = adr; bus.DataInA = din; bus.ReqA = 1'b1;
        end
        lat = 0; en_cnt = 0; we_cnt = 0; got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            lat++;
            en_cnt += int'(bus.MemEn);
            we_cnt += int'(bus.MemWe);
            got = who ? bus.AckB : bus.AckA;
        end
        chk("txn_ack", 32'(got), 32'd1);
        dout = who ? bus.DataOutB : bus.DataOutA;
        bus.ReqA = 1'b0;
        bus.ReqB = 1'b0;
        tick();
    endtask

    task automatic new_req(input logic who);
        logic [15:0] a;
        case ($urandom_range(0, 7))
            0:       a = 16'($urandom);
            1:       a = 16'(32'h1FFE + $urandom_range(0, 3));
            default: a = 16'($urandom_range(0, 31));
        endcase
        if (who) begin
            bus.WrtB = 1'($urandom_range(0, 1)); bus.AdrB = a;
            bus.DataInB = 8'($urandom); bus.ReqB = 1'b1;
        end else begin
            bus.WrtA = 1'($urandom_range(0, 1)); bus.AdrA = a;
            bus.DataInA = 8'($urandom); bus.ReqA = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] dout;
        int         lat, en_cnt, we_cnt, n, acks;
        logic       order [4];

        vecs[0] = '{1'b0, 1'b1, 16'h0100, 8'h5A, 8'h00, 1};
        vecs[1] = '{1'b0, 1'b0, 16'h0100, 8'h00, 8'h5A, 1};
        vecs[2] = '{1'b1, 1'b0, 16'h2000, 8'h00, 8'h00, 0};
        vecs[3] = '{1'b1, 1'b1, 16'h1FFF, 8'hA7, 8'h00, 1};
        vecs[4] = '{1'b1, 1'b0, 16'h1FFF, 8'h00, 8'hA7, 1};
        vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 8'h11, 8'h00, 0};
        vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h00, 0};
        vecs[7] = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'h5A, 1};
        vecs[8] = '{1'b0, 1'b1, 16'h0005, 8'h33, 8'h00, 1};
        vecs[9] = '{1'b0, 1'b1, 16'h0006, 8'h44, 8'h00, 1};

        for (int i = 0; i < int'(MemWords); i++) ref_mem[i] = 8'h00;
        pend = 1'b0; last_who = 1'b1; next_arb = 0; exp_da = 8'h00; exp_db = 8'h00;
        p_cyc = 0; p_who = 1'b0; p_wrt = 1'b0; p_adr = 16'h0; p_din = 8'h0;
        ack_a_seen = 1'b0; ack_b_seen = 1'b0;
        bus.ReqA = 1'b0; bus.WrtA = 1'b0; bus.AdrA = 16'h0; bus.DataInA = 8'h0;
        bus.ReqB = 1'b0; bus.WrtB = 1'b0; bus.AdrB = 16'h0; bus.DataInB = 8'h0;
        rst = 1'b1; ram_clr = 1'b1;
        tick();
        tick();
        rst = 1'b0; ram_clr = 1'b0;
        chk("reset_ack_a", 32'(bus.AckA), 32'd0);
        chk("reset_ack_b", 32'(bus.AckB), 32'd0);
        chk("reset_dout_a", 32'(bus.DataOutA), 32'd0);
        chk("reset_dout_b", 32'(bus.DataOutB), 32'd0);
        chk("reset_mem_en", 32'(bus.MemEn), 32'd0);

        for (int v = 0; v < 10; v++) begin
            do_txn(vecs[v].who, vecs[v].wrt, vecs[v].adr, vecs[v].din, dout, lat, en_cnt, we_cnt);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_mem_en", v), 32'(en_cnt), 32'(vecs[v].exp_en));
            chk($sformatf("vec%0d_mem_we", v), 32'(we_cnt), vecs[v].wrt ? 32'(vecs[v].exp_en) : 32'd0);
            if (!vecs[v].wrt) chk($sformatf("vec%0d_dout", v), 32'(dout), 32'(vecs[v].exp_dout));
        end

        // Input address moves during ACCESS; the latched one must stay on MemAdr.
        bus.WrtA = 1'b0; bus.AdrA = 16'h0005; bus.ReqA = 1'b1;
        tick();
        bus.AdrA = 16'h0006;
        #1;
        chk("adr_latched", 32'(bus.MemAdr), 32'h0005);
        tick();
        chk("adr_latched_ack", 32'(bus.AckA), 32'd1);
        chk("adr_latched_dout", 32'(bus.DataOutA), 32'h33);
        bus.ReqA = 1'b0;
        tick();

        // Both request from the first cycle after reset: A,B,A,B with exclusive Acks.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.WrtA = 1'b0; bus.AdrA = 16'h0100; bus.ReqA = 1'b1;
        bus.WrtB = 1'b0; bus.AdrB = 16'h1FFF; bus.ReqB = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            tick();
            chk("ack_exclusive", 32'(bus.AckA && bus.AckB), 32'd0);
            if (bus.AckA && n < 4) begin order[n] = 1'b0; n++; end
            if (bus.AckB && n < 4) begin order[n] = 1'b1; n++; end
        end
        bus.ReqA = 1'b0; bus.ReqB = 1'b0;
        tick();
        chk("rr_count", 32'(n), 32'd4);
        for (int k = 0; k < 4 && k < n; k++)
            chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 2));

        // Reset during the ACCESS cycle of a write: no Ack, but the data is stored.
        bus.WrtA = 1'b1; bus.AdrA = 16'h0010; bus.DataInA = 8'hC3; bus.ReqA = 1'b1;
        tick();
        chk("abort_mem_we", 32'(bus.MemWe), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.ReqA = 1'b0;
        acks = int'(bus.AckA);
        for (int i = 0; i < 4; i++) begin
            tick();
            acks += int'(bus.AckA);
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        do_txn(1'b0, 1'b0, 16'h0010, 8'h00, dout, lat, en_cnt, we_cnt);
        chk("abort_readback", 32'(dout), 32'hC3);

        // Random traffic; requesters hold until Ack and sometimes re-request at once.
        for (int c = 0; c < 2500; c++) begin
            if (ack_a_seen) begin
                if ($urandom_range(0, 1) == 1) new_req(1'b0);
                else bus.ReqA = 1'b0;
            end else if (!bus.ReqA && $urandom_range(0, 2) == 0) begin
                new_req(1'b0);
            end
            if (ack_b_seen) begin
                if ($urandom_range(0, 1) == 1) new_req(1'b1);
                else bus.ReqB = 1'b0;
            end else if (!bus.ReqB && $urandom_range(0, 2) == 0) begin
                new_req(1'b1);
            end
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; bus.ReqA = 1'b0; bus.ReqB = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 8192, number of 8-bit words in the shared block RAM.
REQ-002 SHALL have parameter MEM_ADR_W, default 13, block RAM address width; MEM_WORDS = 2**MEM_ADR_W.
REQ-003 SHALL have port Clk  input  1  single system clock (SysMainClk domain); all logic on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ReqA  input  1  requester A (CPU) access request, held until AckA.
REQ-006 SHALL have port WrtA  input  1  requester A write (1) / read (0), stable while ReqA.
REQ-007 SHALL have port AdrA  input  16  requester A byte address, stable while ReqA.
REQ-008 SHALL have port DataInA  input  8  requester A write data, stable while ReqA.
REQ-009 SHALL have port DataOutA  output  8  requester A read data, valid when AckA=1, held until next AckA.
REQ-010 SHALL have port AckA  output  1  one-cycle completion pulse to requester A.
REQ-011 SHALL have port ReqB  input  1  requester B (loader/DMA) access request, held until AckB.
REQ-012 SHALL have port WrtB  input  1  requester B write/read select.
REQ-013 SHALL have port AdrB  input  16  requester B byte address.
REQ-014 SHALL have port DataInB  input  8  requester B write data.
REQ-015 SHALL have port DataOutB  output  8  requester B read data, same rules as DataOutA.
REQ-016 SHALL have port AckB  output  1  one-cycle completion pulse to requester B.
REQ-017 SHALL have port MemEn  output  1  block RAM enable (ena).
REQ-018 SHALL have port MemWe  output  1  block RAM write enable (wea).
REQ-019 SHALL have ports MemAdr  output  MEM_ADR_W, MemDin  output  8, MemDout  input  8  block RAM addra/dina/douta; douta has 1-cycle registered read latency.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when ReqA|ReqB, ACCESS->RESP always, RESP->IDLE always.
REQ-021 SHALL in IDLE select the granted requester: sole requester wins; if both request, the one not granted last wins (round-robin); after reset the last-grant flop SHALL point to B so A wins the first tie.
REQ-022 SHALL latch grant, address, write flag and write data on IDLE->ACCESS; later changes on the requester inputs SHALL NOT affect the transaction.
REQ-023 SHALL in ACCESS drive MemEn=1, MemWe=latched write flag, MemAdr=latched address[MEM_ADR_W-1:0], MemDin=latched data; MemEn=MemWe=0 in all other states.
REQ-024 SHALL in RESP pulse exactly one Ack of the granted requester and, for reads, present MemDout on its DataOut; write Acks SHALL leave DataOut unchanged.
REQ-025 SHALL yield latency Req sampled high in IDLE at cycle N -> Ack at cycle N+2; throughput one transaction per 3 cycles.
REQ-026 SHALL treat a latched address >= MEM_WORDS as out of range: no MemEn/MemWe in ACCESS, Ack still at N+2, read DataOut=8'h00.
REQ-027 SHALL NOT treat a Req still high in the cycle after its Ack (IDLE) as the old transaction; it SHALL be arbitrated as a new request.
REQ-028 SHALL guarantee AckA and AckB are never high in the same cycle and MemEn is high at most one cycle per transaction.
REQ-029 SHALL bound starvation: with both requesters continuously requesting, grants SHALL strictly alternate A,B,A,B.

Reset
REQ-030 SHALL on Reset=1 at a rising edge force state IDLE, AckA=AckB=0, DataOutA=DataOutB=8'h00, last-grant=B; MemEn/MemWe low from the following cycle.
REQ-031 SHALL treat Reset asserted during ACCESS as: the RAM write in that cycle completes, no Ack is ever issued for the aborted transaction.

Structure
REQ-032 SHALL place the state enum (IDLE/ACCESS/RESP), the requester-id typedef and default MEM_WORDS constant in shared package pw_mem_arb_pkg.
REQ-033 SHALL implement the tie-break logic and last-grant flop as sub-module rr_arbiter2 (inputs ReqA/ReqB/Take, output grant id).

Verification
REQ-034 Bench SHALL check: A write 0x0100<=8'h5A, then A read 0x0100 -> MemWe pulse 1 cycle, AckA at N+2 each, DataOutA=8'h5A.
REQ-035 Bench SHALL check: ReqA and ReqB rise same cycle after reset, held 4 transactions -> grant order A,B,A,B, no simultaneous Acks.
REQ-036 Bench SHALL check: B read 0x2000 -> no MemEn, AckB at N+2, DataOutB=8'h00.
REQ-037 Bench SHALL check: Reset pulsed during ACCESS of A write 0x0010<=8'hC3 -> no AckA; subsequent read of 0x0010 returns 8'hC3.
REQ-038 Bench SHALL check: AdrA changed from 0x0005 to 0x0006 during ACCESS -> MemAdr stays 0x0005.
